// File: rtl/axi_burst_master_pkg.sv
// Shared types and constants for the single-outstanding AXI burst master.
// The ID width normally comes from the project-wide AXI_ID_WIDTH macro; this fallback keeps the slice standalone.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_burst_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_B
   } state_t;

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam int         ID_W       = `AXI_ID_WIDTH;
   localparam int         BEAT_CNT_W = 9;

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI channel bundle between the burst master and its slave.
// The SIZE, BURST, LOCK, CACHE, PROT and QOS fields are tied off at the system top level.
interface axi_burst_master_if;
   import axi_burst_master_pkg::*;

   logic [ID_W-1:0] AXI_AWID;
   logic [31:0]     AXI_AWADDR;
   logic [7:0]      AXI_AWLEN;
   logic            AXI_AWVALID;
   logic            AXI_AWREADY;

   logic [31:0]     AXI_WDATA;
   logic [3:0]      AXI_WSTRB;
   logic            AXI_WLAST;
   logic            AXI_WVALID;
   logic            AXI_WREADY;

   logic [1:0]      AXI_BRESP;
   logic            AXI_BVALID;
   logic            AXI_BREADY;

   logic [ID_W-1:0] AXI_ARID;
   logic [31:0]     AXI_ARADDR;
   logic [7:0]      AXI_ARLEN;
   logic            AXI_ARVALID;
   logic            AXI_ARREADY;

   logic [31:0]     AXI_RDATA;
   logic [1:0]      AXI_RRESP;
   logic            AXI_RLAST;
   logic            AXI_RVALID;
   logic            AXI_RREADY;

   modport master (
      output AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWVALID,
      input  AXI_AWREADY,
      output AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID,
      input  AXI_WREADY,
      input  AXI_BRESP, AXI_BVALID,
      output AXI_BREADY,
      output AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARVALID,
      input  AXI_ARREADY,
      input  AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID,
      output AXI_RREADY
   );

   modport slave (
      input  AXI_AWID, AXI_AWADDR, AXI_AWLEN, AXI_AWVALID,
      output AXI_AWREADY,
      input  AXI_WDATA, AXI_WSTRB, AXI_WLAST, AXI_WVALID,
      output AXI_WREADY,
      output AXI_BRESP, AXI_BVALID,
      input  AXI_BREADY,
      input  AXI_ARID, AXI_ARADDR, AXI_ARLEN, AXI_ARVALID,
      output AXI_ARREADY,
      output AXI_RDATA, AXI_RRESP, AXI_RLAST, AXI_RVALID,
      input  AXI_RREADY
   );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI INCR burst master: one command in, one read or write burst out.
// Data streams pass straight through to the AXI R/W channels while their state is active.
module axi_burst_master
   import axi_burst_master_pkg::*;
#(
   parameter logic [ID_W-1:0] axi_id_p = '0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [7:0]  cmd_len_i,
   input  logic [31:0] wr_data_i,
   input  logic        wr_valid_i,
   output logic        wr_ready_o,
   output logic [31:0] rd_data_o,
   output logic        rd_last_o,
   output logic        rd_valid_o,
   input  logic        rd_ready_i,
   output logic        done_o,
   output logic        err_o,
   axi_burst_master_if.master axi
);

   state_t                  r_state;
   state_t                  w_stateNext;
   logic [31:0]             r_addr;
   logic [7:0]              r_len;
   logic [BEAT_CNT_W-1:0]   r_beatCnt;
   logic                    r_done;
   logic                    r_err;

   logic w_cntIsLast;
   logic w_cmdAccept;
   logic w_rBeat;
   logic w_wBeat;
   logic w_bDone;

   // Nine-bit counter so a 256-beat burst reaches the compare without wrapping.
   assign w_cntIsLast = (r_beatCnt == {1'b0, r_len});
   assign w_cmdAccept = (r_state == ST_IDLE) && cmd_valid_i;
   assign w_rBeat     = (r_state == ST_R) && axi.AXI_RVALID && rd_ready_i;
   assign w_wBeat     = (r_state == ST_W) && wr_valid_i && axi.AXI_WREADY;
   assign w_bDone     = (r_state == ST_B) && axi.AXI_BVALID;

   assign axi.AXI_AWID   = axi_id_p;
   assign axi.AXI_ARID   = axi_id_p;
   assign axi.AXI_AWADDR = r_addr;
   assign axi.AXI_ARADDR = r_addr;
   assign axi.AXI_AWLEN  = r_len;
   assign axi.AXI_ARLEN  = r_len;
   assign done_o         = r_done;
   assign err_o          = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // VALIDs come from the registered state only, so they never follow READY combinationally.
   always_comb begin
      w_stateNext     = r_state;
      cmd_ready_o     = 1'b0;
      axi.AXI_ARVALID = 1'b0;
      axi.AXI_AWVALID = 1'b0;
      rd_data_o       = '0;
      rd_valid_o      = 1'b0;
      rd_last_o       = 1'b0;
      axi.AXI_RREADY  = 1'b0;
      axi.AXI_WDATA   = '0;
      axi.AXI_WVALID  = 1'b0;
      axi.AXI_WSTRB   = 4'h0;
      axi.AXI_WLAST   = 1'b0;
      wr_ready_o      = 1'b0;
      axi.AXI_BREADY  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) w_stateNext = cmd_write_i ? ST_AW : ST_AR;
         end
         ST_AR: begin
            axi.AXI_ARVALID = 1'b1;
            if (axi.AXI_ARREADY) w_stateNext = ST_R;
         end
         ST_R: begin
            rd_data_o      = axi.AXI_RDATA;
            rd_valid_o     = axi.AXI_RVALID;
            rd_last_o      = w_cntIsLast;
            axi.AXI_RREADY = rd_ready_i;
            if (w_rBeat && w_cntIsLast) w_stateNext = ST_IDLE;
         end
         ST_AW: begin
            axi.AXI_AWVALID = 1'b1;
            if (axi.AXI_AWREADY) w_stateNext = ST_W;
         end
         ST_W: begin
            axi.AXI_WDATA  = wr_data_i;
            axi.AXI_WVALID = wr_valid_i;
            axi.AXI_WSTRB  = 4'hF;
            axi.AXI_WLAST  = w_cntIsLast;
            wr_ready_o     = axi.AXI_WREADY;
            if (w_wBeat && w_cntIsLast) w_stateNext = ST_B;
         end
         ST_B: begin
            axi.AXI_BREADY = 1'b1;
            if (axi.AXI_BVALID) w_stateNext = ST_IDLE;
         end
         default: w_stateNext = ST_IDLE;
      endcase
   end

   // Reads finish by count even if the slave's RLAST disagrees; the mismatch only raises err.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr    <= '0;
         r_len     <= '0;
         r_beatCnt <= '0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= (w_rBeat && w_cntIsLast) || w_bDone;
         if (w_cmdAccept) begin
            r_addr    <= cmd_addr_i & ~32'h3;
            r_len     <= cmd_len_i;
            r_beatCnt <= '0;
            r_err     <= 1'b0;
         end
         if (w_rBeat) begin
            r_beatCnt <= r_beatCnt + 9'd1;
            if ((axi.AXI_RRESP != RESP_OKAY) || (axi.AXI_RLAST != w_cntIsLast)) r_err <= 1'b1;
         end
         if (w_wBeat) r_beatCnt <= r_beatCnt + 9'd1;
         if (w_bDone && (axi.AXI_BRESP != RESP_OKAY)) r_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master against a small word-addressed memory slave.
// The slave adds a two-cycle delay on AWREADY/ARREADY so the VALID hold behaviour is exercised.
module tb_axi_burst_master;
   import axi_burst_master_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmdValid = 1'b0;
   logic        cmdWrite = 1'b0;
   logic [31:0] cmdAddr = '0;
   logic [7:0]  cmdLen = '0;
   logic [31:0] wrData = '0;
   logic        wrValid = 1'b0;
   logic        rdReady = 1'b0;
   logic        cmdReady, wrReady, rdLast, rdValid, done, err;
   logic [31:0] rdData;

   int          nChecks = 0;
   int          nPass = 0;
   logic [31:0] expQ[$];
   logic [31:0] wrQ[$];
   logic [1:0]  tbBresp = 2'b00;
   logic [1:0]  tbRresp = 2'b00;

   axi_burst_master_if bus ();

   axi_burst_master #(.axi_id_p('0)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_write_i(cmdWrite),
      .cmd_addr_i(cmdAddr), .cmd_len_i(cmdLen),
      .wr_data_i(wrData), .wr_valid_i(wrValid), .wr_ready_o(wrReady),
      .rd_data_o(rdData), .rd_last_o(rdLast), .rd_valid_o(rdValid), .rd_ready_i(rdReady),
      .done_o(done), .err_o(err), .axi(bus.master)
   );

   always #5 clk = ~clk;

   // Memory slave: one read and one write burst tracker, reset alongside the master.
   logic [31:0] mem [0:1023];
   logic [1:0]  arWait, awWait;
   logic        rActive, wActive;
   logic [9:0]  rBase, wBase;
   logic [7:0]  rLen, rIdx, wIdx;

   assign bus.AXI_RRESP = bus.AXI_RVALID ? tbRresp : 2'b00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[16 + i] <= 32'hA5A5_000A + i;
         bus.AXI_ARREADY <= 1'b0; bus.AXI_AWREADY <= 1'b0; bus.AXI_WREADY <= 1'b0;
         bus.AXI_RVALID  <= 1'b0; bus.AXI_RLAST   <= 1'b0; bus.AXI_RDATA  <= '0;
         bus.AXI_BVALID  <= 1'b0; bus.AXI_BRESP   <= 2'b00;
         arWait <= '0; awWait <= '0; rActive <= 1'b0; wActive <= 1'b0;
         rBase <= '0; wBase <= '0; rLen <= '0; rIdx <= '0; wIdx <= '0;
      end else begin
         if (bus.AXI_ARVALID && bus.AXI_ARREADY) begin
            bus.AXI_ARREADY <= 1'b0; arWait <= '0; rActive <= 1'b1;
            rBase <= bus.AXI_ARADDR[11:2]; rLen <= bus.AXI_ARLEN; rIdx <= '0;
            bus.AXI_RVALID <= 1'b1; bus.AXI_RDATA <= mem[bus.AXI_ARADDR[11:2]];
            bus.AXI_RLAST  <= (bus.AXI_ARLEN == 8'd0);
         end else if (bus.AXI_ARVALID && !rActive) begin
            if (arWait == 2'd1) bus.AXI_ARREADY <= 1'b1;
            arWait <= arWait + 2'd1;
         end
         if (bus.AXI_RVALID && bus.AXI_RREADY) begin
            if (bus.AXI_RLAST) begin
               bus.AXI_RVALID <= 1'b0; bus.AXI_RLAST <= 1'b0; rActive <= 1'b0;
            end else begin
               rIdx <= rIdx + 8'd1;
               bus.AXI_RDATA <= mem[rBase + {2'b00, rIdx} + 10'd1];
               bus.AXI_RLAST <= ((rIdx + 8'd1) == rLen);
            end
         end
         if (bus.AXI_AWVALID && bus.AXI_AWREADY) begin
            bus.AXI_AWREADY <= 1'b0; awWait <= '0; wActive <= 1'b1;
            wBase <= bus.AXI_AWADDR[11:2]; wIdx <= '0; bus.AXI_WREADY <= 1'b1;
         end else if (bus.AXI_AWVALID && !wActive) begin
            if (awWait == 2'd1) bus.AXI_AWREADY <= 1'b1;
            awWait <= awWait + 2'd1;
         end
         if (bus.AXI_WVALID && bus.AXI_WREADY) begin
            mem[wBase + {2'b00, wIdx}] <= bus.AXI_WDATA;
            wIdx <= wIdx + 8'd1;
            if (bus.AXI_WLAST) begin
               bus.AXI_WREADY <= 1'b0; bus.AXI_BVALID <= 1'b1; bus.AXI_BRESP <= tbBresp;
            end
         end
         if (bus.AXI_BVALID && bus.AXI_BREADY) begin
            bus.AXI_BVALID <= 1'b0; bus.AXI_BRESP <= 2'b00; wActive <= 1'b0;
         end
      end
   end

   // Everything the master drives except cmd_ready_o, concatenated for the reset checks.
   function automatic logic [190:0] allOutputs();
      return {wrReady, rdLast, rdValid, done, err, rdData,
              bus.AXI_ARVALID, bus.AXI_AWVALID, bus.AXI_ARADDR, bus.AXI_AWADDR,
              bus.AXI_ARLEN, bus.AXI_AWLEN, bus.AXI_WVALID, bus.AXI_WDATA, bus.AXI_WSTRB,
              bus.AXI_WLAST, bus.AXI_BREADY, bus.AXI_RREADY, bus.AXI_ARID, bus.AXI_AWID,
              {(183 - 2 * ID_W - 160 - 10 - 5){1'b0}}};
   endfunction

   task automatic issue_cmd(input logic write, input logic [31:0] addr, input logic [7:0] len);
      int waitCyc = 0;
      @(negedge clk);
      cmdValid = 1'b1; cmdWrite = write; cmdAddr = addr; cmdLen = len;
      #1;
      while (!cmdReady && waitCyc < 100) begin
         @(negedge clk); #1; waitCyc++;
      end
      nChecks++;
      if (cmdReady !== 1'b1) $display("[TB] FAIL cmd_accept: cmd_ready_o=%b required 1", cmdReady);
      else nPass++;
      @(negedge clk);
      cmdValid = 1'b0;
      #1;
      nChecks++;
      if (err !== 1'b0) $display("[TB] FAIL err_clear_on_accept: err_o=%b required 0", err);
      else nPass++;
   endtask

   task automatic collect_read(input string name, input int len, input bit toggle,
                               input logic [31:0] expAddr, input logic expErr);
      int beats = 0, dones = 0, cyc = 0, after = 0;
      bit sawAr = 1'b0;
      while (cyc < 3000 && after < 3) begin
         @(negedge clk);
         rdReady = toggle ? cyc[0] : 1'b1;
         #1;
         if (bus.AXI_ARVALID && !sawAr) begin
            sawAr = 1'b1; nChecks++;
            if (bus.AXI_ARADDR !== expAddr || bus.AXI_ARLEN !== len[7:0])
               $display("[TB] FAIL %s_araddr: got %h/%0d required %h/%0d", name,
                        bus.AXI_ARADDR, bus.AXI_ARLEN, expAddr, len);
            else nPass++;
         end
         if (rdValid && rdReady) begin
            if (beats < expQ.size()) begin
               nChecks++;
               if (rdData !== expQ[beats])
                  $display("[TB] FAIL %s_data[%0d]: got %h required %h", name, beats, rdData, expQ[beats]);
               else nPass++;
            end
            nChecks++;
            if (rdLast !== (beats == len))
               $display("[TB] FAIL %s_rd_last[%0d]: got %b required %b", name, beats, rdLast, beats == len);
            else nPass++;
            beats++;
         end
         if (done) dones++;
         if (dones != 0) after++;
         cyc++;
      end
      rdReady = 1'b0;
      nChecks++;
      if (beats != len + 1) $display("[TB] FAIL %s_beats: got %0d required %0d", name, beats, len + 1);
      else nPass++;
      nChecks++;
      if (dones != 1) $display("[TB] FAIL %s_done: got %0d pulses required 1", name, dones);
      else nPass++;
      nChecks++;
      if (err !== expErr) $display("[TB] FAIL %s_err: got %b required %b", name, err, expErr);
      else nPass++;
   endtask

   task automatic collect_write(input string name, input int len, input bit gappy,
                                input logic [31:0] expAddr, input logic expErr);
      int beats = 0, dones = 0, cyc = 0, after = 0, bHand = 0;
      bit sawAw = 1'b0;
      while (cyc < 3000 && after < 3) begin
         @(negedge clk);
         if (beats <= len && !(gappy && (cyc % 3 == 2))) begin
            wrValid = 1'b1; wrData = wrQ[beats];
         end else begin
            wrValid = 1'b0; wrData = '0;
         end
         #1;
         if (bus.AXI_AWVALID && !sawAw) begin
            sawAw = 1'b1; nChecks++;
            if (bus.AXI_AWADDR !== expAddr || bus.AXI_AWLEN !== len[7:0] || bus.AXI_AWID !== '0)
               $display("[TB] FAIL %s_awaddr: got %h/%0d required %h/%0d", name,
                        bus.AXI_AWADDR, bus.AXI_AWLEN, expAddr, len);
            else nPass++;
         end
         if (bus.AXI_WVALID && bus.AXI_WREADY) begin
            if (beats < wrQ.size()) begin
               nChecks++;
               if (bus.AXI_WDATA !== wrQ[beats] || bus.AXI_WSTRB !== 4'hF || wrReady !== 1'b1)
                  $display("[TB] FAIL %s_wdata[%0d]: got %h strb %h required %h strb f", name,
                           beats, bus.AXI_WDATA, bus.AXI_WSTRB, wrQ[beats]);
               else nPass++;
            end
            nChecks++;
            if (bus.AXI_WLAST !== (beats == len))
               $display("[TB] FAIL %s_wlast[%0d]: got %b required %b", name, beats, bus.AXI_WLAST, beats == len);
            else nPass++;
            beats++;
         end
         if (bus.AXI_BVALID && bus.AXI_BREADY) bHand++;
         if (done) dones++;
         if (dones != 0) after++;
         cyc++;
      end
      wrValid = 1'b0;
      nChecks++;
      if (beats != len + 1) $display("[TB] FAIL %s_beats: got %0d required %0d", name, beats, len + 1);
      else nPass++;
      nChecks++;
      if (bHand != 1 || dones != 1)
         $display("[TB] FAIL %s_b_done: got %0d B handshakes %0d done pulses required 1 and 1", name, bHand, dones);
      else nPass++;
      nChecks++;
      if (err !== expErr) $display("[TB] FAIL %s_err: got %b required %b", name, err, expErr);
      else nPass++;
   endtask

   task automatic loadReadExp(input int n);
      expQ.delete();
      for (int i = 0; i < n; i++) expQ.push_back(32'hA5A5_000A + i);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #3;
      nChecks++;
      if (allOutputs() !== '0) $display("[TB] FAIL reset_outputs: got %h required 0", allOutputs());
      else nPass++;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      #1;
      nChecks++;
      if (cmdReady !== 1'b1) $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmdReady);
      else nPass++;
   endtask

   task automatic test_read();
      loadReadExp(4);
      issue_cmd(1'b0, 32'h40, 8'd3);
      collect_read("read4", 3, 1'b0, 32'h40, 1'b0);
   endtask

   task automatic test_write_read();
      wrQ.delete(); wrQ.push_back(32'hDEADBEEF);
      issue_cmd(1'b1, 32'h100, 8'd0);
      collect_write("write1", 0, 1'b0, 32'h100, 1'b0);
      expQ.delete(); expQ.push_back(32'hDEADBEEF);
      issue_cmd(1'b0, 32'h100, 8'd0);
      collect_read("readback1", 0, 1'b0, 32'h100, 1'b0);
   endtask

   task automatic test_addr_align();
      expQ.delete(); expQ.push_back(32'hA5A5_000D);
      issue_cmd(1'b0, 32'h4F, 8'd0);
      collect_read("align", 0, 1'b0, 32'h4C, 1'b0);
   endtask

   task automatic test_backpressure();
      loadReadExp(8);
      issue_cmd(1'b0, 32'h40, 8'd7);
      collect_read("bp8", 7, 1'b1, 32'h40, 1'b0);
   endtask

   task automatic test_max_burst();
      wrQ.delete();
      for (int i = 0; i < 256; i++) wrQ.push_back(32'hC000_0000 + i);
      issue_cmd(1'b1, 32'h400, 8'd255);
      collect_write("max_wr", 255, 1'b1, 32'h400, 1'b0);
      expQ = wrQ;
      issue_cmd(1'b0, 32'h400, 8'd255);
      collect_read("max_rd", 255, 1'b0, 32'h400, 1'b0);
   endtask

   task automatic test_busy();
      loadReadExp(4);
      issue_cmd(1'b0, 32'h40, 8'd3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 32'h200;
         #1;
         nChecks++;
         if (cmdReady !== 1'b0 || bus.AXI_AWVALID !== 1'b0)
            $display("[TB] FAIL busy_hold[%0d]: cmd_ready_o=%b awvalid=%b required 0/0", i, cmdReady, bus.AXI_AWVALID);
         else nPass++;
      end
      cmdValid = 1'b0;
      collect_read("busy", 3, 1'b0, 32'h40, 1'b0);
   endtask

   task automatic test_write_error();
      tbBresp = 2'b10;
      wrQ.delete(); wrQ.push_back(32'h1111_0000); wrQ.push_back(32'h2222_0000);
      issue_cmd(1'b1, 32'h200, 8'd1);
      collect_write("wr_err", 1, 1'b0, 32'h200, 1'b1);
      tbBresp = 2'b00;
      @(negedge clk); @(negedge clk); #1;
      nChecks++;
      if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b required 1", err);
      else nPass++;
      loadReadExp(4);
      issue_cmd(1'b0, 32'h40, 8'd3);
      collect_read("after_err", 3, 1'b0, 32'h40, 1'b0);
   endtask

   task automatic test_read_error();
      tbRresp = 2'b10;
      loadReadExp(2);
      issue_cmd(1'b0, 32'h40, 8'd1);
      collect_read("rd_err", 1, 1'b0, 32'h40, 1'b1);
      tbRresp = 2'b00;
   endtask

   task automatic test_reset_abort();
      int beats = 0, cyc = 0, dones = 0;
      issue_cmd(1'b0, 32'h40, 8'd7);
      while (beats < 2 && cyc < 200) begin
         @(negedge clk);
         rdReady = 1'b1;
         #1;
         if (rdValid && rdReady) beats++;
         cyc++;
      end
      nChecks++;
      if (beats != 2) $display("[TB] FAIL abort_reach_beat2: got %0d beats required 2", beats);
      else nPass++;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      nChecks++;
      if (allOutputs() !== '0) $display("[TB] FAIL abort_outputs: got %h required 0", allOutputs());
      else nPass++;
      rdReady = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      nChecks++;
      if (cmdReady !== 1'b1) $display("[TB] FAIL abort_cmd_ready: got %b required 1", cmdReady);
      else nPass++;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (done) dones++;
      end
      nChecks++;
      if (dones != 0) $display("[TB] FAIL abort_no_done: got %0d pulses required 0", dones);
      else nPass++;
      loadReadExp(4);
      issue_cmd(1'b0, 32'h40, 8'd3);
      collect_read("recover", 3, 1'b0, 32'h40, 1'b0);
   endtask

   initial begin
      $display("[TB] starting axi_burst_master bench");
      test_reset();
      test_read();
      test_write_read();
      test_addr_align();
      test_backpressure();
      test_busy();
      test_max_burst();
      test_write_error();
      test_read_error();
      test_reset_abort();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
